mem_port_arbiter: RTL

- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch (IF) stage and its load/store (MEM) stage.
- Owns a request/grant FSM and a latency counter, and registers the memory command.
- Returns read data and completion pulses to each requester.
- Drives the pipeline stall lines: stall_if gates PC write and IF/ID write; stall_mem freezes the whole pipeline.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_lat_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
// Holds FSM state and grant-source enums plus the latency counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      SRC_FETCH = 1'b0,
      SRC_DATA  = 1'b1
   } src_t;

   localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable 4-bit down-counter timing the memory read latency.
// rst is a synchronous active-low clear; last flags count == 1.
module mem_arb_lat_cnt
   import mem_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 dec,
   input  logic [LAT_CNT_W-1:0] init,
   output logic                 last
);

   logic [LAT_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= init;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between IF and MEM stages.
// Define MEM_PORT_ARBITER_RR_EN for alternating priority under contention.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   state_t state;
   src_t   src;
   logic   is_store;
   logic   grant_d;
   logic   cnt_last;

`ifdef MEM_PORT_ARBITER_RR_EN
   src_t last_src;

   // Under contention, whoever won last time yields.
   assign grant_d = d_req & ~(if_req & (last_src == SRC_DATA));

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_src <= SRC_FETCH;
      end else if (state == IDLE && (d_req || if_req)) begin
         last_src <= grant_d ? SRC_DATA : SRC_FETCH;
      end
   end
`else
   assign grant_d = d_req;
`endif

   mem_arb_lat_cnt u_lat_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (state == ISSUE && !is_store),
      .dec  (state == WAIT),
      .init (LAT_CNT_W'(MEM_LAT)),
      .last (cnt_last)
   );

   assign stall_mem = d_req & ~d_valid;
   assign stall_if  = (if_req & ~if_valid) | stall_mem;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         src       <= SRC_FETCH;
         is_store  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_d) begin
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_we    <= d_we;
                  mem_re    <= ~d_we;
                  is_store  <= d_we;
                  src       <= SRC_DATA;
                  state     <= ISSUE;
               end else if (if_req) begin
                  mem_addr <= if_addr;
                  mem_re   <= 1'b1;
                  is_store <= 1'b0;
                  src      <= SRC_FETCH;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_re <= 1'b0;
               mem_we <= 1'b0;
               if (is_store) begin
                  d_valid <= 1'b1;
                  state   <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_last) begin
                  if (src == SRC_FETCH) begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end else begin
                     d_rdata <= mem_rdata;
                     d_valid <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               // Requester still shows its old req here, so no grant.
               if_valid <= 1'b0;
               d_valid  <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
